// File: rtl/jogo_memoria_param.sv
// Parametrised memory-game core: shows mem[0], checks growing press sequences, optional append mode.
// Optional press timeout enabled by defining JOGO_TIMEOUT_EN.
module jogo_memoria_param #(
  parameter int unsigned N_BOTOES       = 4,
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned RODADAS        = 16,
  parameter int unsigned MOSTRA_CICLOS  = 2000,
  parameter int unsigned TIMEOUT_CICLOS = 3000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic                modo,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [N_BOTOES-1:0] mem_dado,
  output logic                ganhou,
  output logic                perdeu,
  output logic                pronto,
  output logic [N_BOTOES-1:0] leds,
  output logic [3:0]          db_estado,
  output logic [ADDR_W-1:0]   db_rodada,
  output logic [ADDR_W-1:0]   db_contagem,
  output logic                db_timeout
);

  localparam int unsigned MW = (MOSTRA_CICLOS > 1) ? $clog2(MOSTRA_CICLOS) : 1;
  localparam int unsigned PROF = 1 << ADDR_W;
  localparam logic [MW-1:0]     MOSTRA_FIM  = MW'(MOSTRA_CICLOS - 1);
  localparam logic [ADDR_W-1:0] RODADA_FIM  = ADDR_W'(RODADAS - 1);

  typedef enum logic [3:0] {
    INICIAL      = 4'h0,
    PREPARA      = 4'h1,
    MOSTRA       = 4'h2,
    ESPERA       = 4'h3,
    REGISTRA     = 4'h4,
    COMPARA      = 4'h5,
    PROX_JOGADA  = 4'h6,
    PROX_RODADA  = 4'h7,
    ESPERA_GRAVA = 4'h8,
    GRAVA        = 4'h9,
    GANHOU       = 4'hA,
    PERDEU       = 4'hB
  } estado_t;

  estado_t             estado_q, estado_d;
  logic [N_BOTOES-1:0] b_r_q, b_p_q;
  logic [N_BOTOES-1:0] jogada_q, jogada_d;
  logic [ADDR_W-1:0]   rodada_q, rodada_d;
  logic [ADDR_W-1:0]   endereco_q, endereco_d;
  logic [MW-1:0]       mostra_q, mostra_d;
  logic                modo_q, modo_d;
  logic                ganhou_q, ganhou_d;
  logic                perdeu_q, perdeu_d;
  logic                pronto_q;
  logic [N_BOTOES-1:0] leds_q, leds_d;
  logic [N_BOTOES-1:0] mem_q [PROF];

  logic                evento_c, espera_c, expira_c, multi_c;
  logic                mem_wr_c;
  logic [ADDR_W-1:0]   mem_wa_c;
  logic [N_BOTOES-1:0] mem_wd_c;

  assign evento_c = (b_r_q != '0) && (b_p_q == '0);
  assign espera_c = (estado_q == ESPERA) || (estado_q == ESPERA_GRAVA);
  assign multi_c  = (jogada_q & (jogada_q - N_BOTOES'(1))) != '0;

`ifdef JOGO_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [TW-1:0] TIMEOUT_FIM = TW'(TIMEOUT_CICLOS - 1);
  logic [TW-1:0] timer_q;
  logic          timeout_q;

  assign expira_c = espera_c && !evento_c && (timer_q == TIMEOUT_FIM);

  // Timer runs only while waiting for a press; every other state restarts it.
  always_ff @(posedge clock) begin
    if (reset) begin
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timer_q <= (espera_c && !evento_c && !expira_c) ? timer_q + TW'(1) : '0;
      if (estado_q == PREPARA)
        timeout_q <= 1'b0;
      else if (expira_c)
        timeout_q <= 1'b1;
    end
  end

  assign db_timeout = timeout_q;
`else
  assign expira_c   = 1'b0;
  assign db_timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= INICIAL;
      b_r_q      <= '0;
      b_p_q      <= '0;
      jogada_q   <= '0;
      rodada_q   <= '0;
      endereco_q <= '0;
      mostra_q   <= '0;
      modo_q     <= 1'b0;
      ganhou_q   <= 1'b0;
      perdeu_q   <= 1'b0;
      pronto_q   <= 1'b0;
      leds_q     <= '0;
    end else begin
      estado_q   <= estado_d;
      b_r_q      <= botoes;
      b_p_q      <= b_r_q;
      jogada_q   <= jogada_d;
      rodada_q   <= rodada_d;
      endereco_q <= endereco_d;
      mostra_q   <= mostra_d;
      modo_q     <= modo_d;
      ganhou_q   <= ganhou_d;
      perdeu_q   <= perdeu_d;
      pronto_q   <= ganhou_d | perdeu_d;
      leds_q     <= leds_d;
    end
  end

  // Sequence RAM survives reset on purpose so a preloaded game can be replayed.
  always_ff @(posedge clock) begin
    if (mem_wr_c)
      mem_q[mem_wa_c] <= mem_wd_c;
  end

  always_comb begin
    estado_d   = estado_q;
    jogada_d   = jogada_q;
    rodada_d   = rodada_q;
    endereco_d = endereco_q;
    mostra_d   = mostra_q;
    modo_d     = modo_q;
    ganhou_d   = ganhou_q;
    perdeu_d   = perdeu_q;
    mem_wr_c   = 1'b0;
    mem_wa_c   = mem_addr;
    mem_wd_c   = mem_dado;
    case (estado_q)
      INICIAL, GANHOU, PERDEU: begin
        mem_wr_c = mem_we;
        if (iniciar) estado_d = PREPARA;
      end
      PREPARA: begin
        rodada_d   = '0;
        endereco_d = '0;
        mostra_d   = '0;
        ganhou_d   = 1'b0;
        perdeu_d   = 1'b0;
        modo_d     = modo;
        estado_d   = MOSTRA;
      end
      MOSTRA: begin
        if (mostra_q == MOSTRA_FIM) estado_d = ESPERA;
        else                        mostra_d = mostra_q + MW'(1);
      end
      ESPERA, ESPERA_GRAVA: begin
        if (evento_c) begin
          jogada_d = b_r_q;
          estado_d = (estado_q == ESPERA) ? REGISTRA : GRAVA;
        end else if (expira_c) begin
          perdeu_d = 1'b1;
          estado_d = PERDEU;
        end
      end
      REGISTRA: begin
        jogada_d = b_r_q;
        estado_d = COMPARA;
      end
      COMPARA: begin
        if (multi_c || (jogada_q != mem_q[endereco_q])) begin
          perdeu_d = 1'b1;
          estado_d = PERDEU;
        end else if (endereco_q == rodada_q) begin
          estado_d = PROX_RODADA;
        end else begin
          estado_d = PROX_JOGADA;
        end
      end
      PROX_JOGADA: begin
        endereco_d = endereco_q + ADDR_W'(1);
        estado_d   = ESPERA;
      end
      PROX_RODADA: begin
        if (rodada_q == RODADA_FIM) begin
          ganhou_d = 1'b1;
          estado_d = GANHOU;
        end else begin
          rodada_d   = rodada_q + ADDR_W'(1);
          endereco_d = '0;
          estado_d   = modo_q ? ESPERA_GRAVA : ESPERA;
        end
      end
      GRAVA: begin
        mem_wr_c = 1'b1;
        mem_wa_c = rodada_q;
        mem_wd_c = jogada_q;
        estado_d = ESPERA;
      end
      default: estado_d = INICIAL;
    endcase
  end

  // LEDs registered from the next state so they line up with db_estado.
  always_comb begin
    leds_d = '0;
    case (estado_d)
      MOSTRA:               leds_d = mem_q[0];
      ESPERA, ESPERA_GRAVA: leds_d = botoes;
      default:              leds_d = '0;
    endcase
  end

  assign ganhou      = ganhou_q;
  assign perdeu      = perdeu_q;
  assign pronto      = pronto_q;
  assign leds        = leds_q;
  assign db_estado   = estado_q;
  assign db_rodada   = rodada_q;
  assign db_contagem = endereco_q;

endmodule

// File: tb/tb_jogo_memoria_param.sv
// Directed bench for jogo_memoria_param; timeout expectations follow JOGO_TIMEOUT_EN.
module tb_jogo_memoria_param;

  logic       clock, reset, iniciar, modo, mem_we;
  logic [3:0] botoes, mem_addr, mem_dado;
  logic       ganhou, perdeu, pronto, db_timeout;
  logic [3:0] leds, db_estado, db_rodada, db_contagem;

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] seq_a [16];

  jogo_memoria_param #(
    .N_BOTOES(4), .ADDR_W(4), .RODADAS(16),
    .MOSTRA_CICLOS(20), .TIMEOUT_CICLOS(100)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .modo(modo),
    .botoes(botoes), .mem_we(mem_we), .mem_addr(mem_addr), .mem_dado(mem_dado),
    .ganhou(ganhou), .perdeu(perdeu), .pronto(pronto), .leds(leds),
    .db_estado(db_estado), .db_rodada(db_rodada), .db_contagem(db_contagem),
    .db_timeout(db_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ciclos(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ciclos(2);
    reset = 1'b0;
    ciclos(1);
  endtask

  task automatic preload_a();
    for (int i = 0; i < 16; i++) begin
      mem_we = 1'b1; mem_addr = 4'(i); mem_dado = seq_a[i];
      ciclos(1);
    end
    mem_we = 1'b0;
  endtask

  task automatic wait_estado(input logic [3:0] code, input int budget, input string tag);
    int n = 0;
    while (db_estado !== code && n < budget) begin
      ciclos(1);
      n++;
    end
    chk(tag, 32'(db_estado), 32'(code));
  endtask

  // Start a game and verify the mem[0] display window.
  task automatic start(input logic m, input logic [3:0] exp_leds, input string tag);
    int n = 0;
    int bad = 0;
    modo = m;
    iniciar = 1'b1;
    wait_estado(4'h2, 10, {tag, "_enter_mostra"});
    iniciar = 1'b0;
    while (db_estado == 4'h2 && n < 1000) begin
      if (leds !== exp_leds) bad++;
      n++;
      ciclos(1);
    end
    chk({tag, "_mostra_len"}, 32'(n), 32'd20);
    chk({tag, "_mostra_leds_bad"}, 32'(bad), 32'd0);
    chk({tag, "_espera_state"}, 32'(db_estado), 32'h3);
    chk({tag, "_espera_leds"}, 32'(leds), 32'h0);
  endtask

  task automatic press(input logic [3:0] v);
    botoes = v;
    ciclos(10);
    botoes = 4'h0;
    ciclos(10);
  endtask

  task automatic play(input int wr, input int wk);
    for (int r = 0; r < 16; r++)
      for (int k = 0; k <= r; k++)
        press((r == wr && k == wk) ? 4'h1 : seq_a[k]);
  endtask

  initial begin
    seq_a = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2,
              4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2, 4'h4, 4'h8};
    reset = 1'b1; iniciar = 1'b0; modo = 1'b0; botoes = 4'h0;
    mem_we = 1'b0; mem_addr = 4'h0; mem_dado = 4'h0;
    ciclos(2);
    chk("rst_estado", 32'(db_estado), 32'h0);
    chk("rst_flags", 32'({ganhou, perdeu, pronto, db_timeout}), 32'h0);
    chk("rst_leds", 32'(leds), 32'h0);
    chk("rst_cnt", 32'({db_rodada, db_contagem}), 32'h0);
    reset = 1'b0;
    ciclos(1);

    // Full win
    preload_a();
    start(1'b0, 4'h1, "win");
    play(-1, -1);
    chk("win_ganhou", 32'(ganhou), 32'd1);
    chk("win_pronto", 32'(pronto), 32'd1);
    chk("win_perdeu", 32'(perdeu), 32'd0);
    chk("win_estado", 32'(db_estado), 32'hA);
    chk("win_rodada", 32'(db_rodada), 32'hF);

    // Wrong final press
    do_reset();
    preload_a();
    start(1'b0, 4'h1, "wrong");
    play(15, 15);
    chk("wrong_perdeu", 32'(perdeu), 32'd1);
    chk("wrong_ganhou", 32'(ganhou), 32'd0);
    chk("wrong_timeout", 32'(db_timeout), 32'd0);
    chk("wrong_estado", 32'(db_estado), 32'hB);
    chk("wrong_contagem", 32'(db_contagem), 32'hF);
    chk("wrong_rodada", 32'(db_rodada), 32'hF);

    // No press after the display window
    do_reset();
    start(1'b0, 4'h1, "tmo");
    ciclos(1000);
`ifdef JOGO_TIMEOUT_EN
    chk("tmo_perdeu", 32'(perdeu), 32'd1);
    chk("tmo_flag", 32'(db_timeout), 32'd1);
    chk("tmo_estado", 32'(db_estado), 32'hB);
    chk("tmo_pronto", 32'(pronto), 32'd1);
`else
    chk("tmo_perdeu", 32'(perdeu), 32'd0);
    chk("tmo_flag", 32'(db_timeout), 32'd0);
    chk("tmo_estado", 32'(db_estado), 32'h3);
`endif

    // Two-button first press always loses
    do_reset();
    start(1'b0, 4'h1, "multi");
    botoes = 4'h3;
    ciclos(1);
    chk("multi_leds", 32'(leds), 32'h3);
    ciclos(9);
    botoes = 4'h0;
    ciclos(10);
    chk("multi_perdeu", 32'(perdeu), 32'd1);
    chk("multi_estado", 32'(db_estado), 32'hB);
    chk("multi_timeout", 32'(db_timeout), 32'd0);

    // Reset while comparing
    do_reset();
    start(1'b0, 4'h1, "rst5");
    botoes = 4'h1;
    wait_estado(4'h5, 10, "rst5_reach_compara");
    reset = 1'b1;
    ciclos(1);
    chk("rst5_estado", 32'(db_estado), 32'h0);
    chk("rst5_flags", 32'({ganhou, perdeu, pronto, db_timeout}), 32'h0);
    chk("rst5_leds", 32'(leds), 32'h0);
    chk("rst5_cnt", 32'({db_rodada, db_contagem}), 32'h0);
    reset = 1'b0;
    botoes = 4'h0;
    ciclos(2);
    start(1'b0, 4'h1, "rst5_ram_kept");

    // Preload strobe outside idle must be ignored
    do_reset();
    start(1'b0, 4'h1, "we");
    mem_we = 1'b1; mem_addr = 4'h0; mem_dado = 4'h8;
    ciclos(1);
    mem_we = 1'b0;
    press(4'h1);
    chk("we_perdeu", 32'(perdeu), 32'd0);
    chk("we_rodada", 32'(db_rodada), 32'h1);
    chk("we_estado", 32'(db_estado), 32'h3);

    // Append mode: mem[1] is overwritten by the recorded press
    do_reset();
    preload_a();
    start(1'b1, 4'h1, "app");
    press(4'h1);
    chk("app_r0_estado", 32'(db_estado), 32'h8);
    chk("app_r0_rodada", 32'(db_rodada), 32'h1);
    press(4'h4);
    chk("app_grava_estado", 32'(db_estado), 32'h3);
    press(4'h1);
    press(4'h4);
    chk("app_perdeu", 32'(perdeu), 32'd0);
    chk("app_r1_estado", 32'(db_estado), 32'h8);
    chk("app_r1_rodada", 32'(db_rodada), 32'h2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
